// File: rtl/apb_i2c_regs.sv
// apb_i2c_regs: APB3 slave register front end for the I2C master core.
// Runs a two-state setup/access handshake with programmable wait states,
// decodes an 8-entry register map and drives single-cycle FIFO strobes.
// Ports:
//   PCLK, PRESET              clock, asynchronous active-high reset
//   PSEL/PENABLE/PWRITE       APB control
//   PADDR, PWDATA             APB address / write data
//   PRDATA/PREADY/PSLVERR     APB response (combinational, single-cycle)
//   status_in, tx_full,       core status and FIFO flags
//   rx_empty, rx_data
//   tx_data, tx_push, rx_pop  FIFO write data and push/pop strobes
//   prescale_reg, address_reg, command_reg   control registers to the core
module apb_i2c_regs #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned PRESCALE_RST = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [1:0]        status_in,
    input  logic              tx_full,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_push,
    output logic              rx_pop,
    output logic [DATA_W-1:0] prescale_reg,
    output logic [7:0]        address_reg,
    output logic [DATA_W-1:0] command_reg
);

    localparam int unsigned CNT_W = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [2:0] A_PRESCALE = 3'd0;
    localparam logic [2:0] A_COMMAND  = 3'd1;
    localparam logic [2:0] A_ADDRESS  = 3'd2;
    localparam logic [2:0] A_TXDATA   = 3'd3;
    localparam logic [2:0] A_RXDATA   = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_prescale;
    logic [DATA_W-1:0] r_command;
    logic [7:0]        r_address;
    logic [7:0]        r_tx_data;

    logic [0:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_latch;
    logic              w_ready;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;
    logic              w_push_sel;
    logic              w_pop_sel;
    logic              w_wr_pre;
    logic              w_wr_cmd;
    logic              w_wr_adr;
    logic              w_tx_push;

    // Next-state logic: setup latches the request, access counts down the wait states
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = CNT_W'(WAIT_STATES);
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_ready     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Register-map decode on the latched request; a changed address/direction is an error
    always_comb begin
        w_err      = 1'b0;
        w_rdata    = '0;
        w_push_sel = 1'b0;
        w_pop_sel  = 1'b0;
        w_wr_pre   = 1'b0;
        w_wr_cmd   = 1'b0;
        w_wr_adr   = 1'b0;
        if (((r_addr >> 3) != '0) || (PADDR != r_addr) || (PWRITE != r_write)) begin
            w_err = 1'b1;
        end else begin
            case (r_addr[2:0])
                A_PRESCALE: begin
                    if (r_write) w_wr_pre = 1'b1;
                    else         w_rdata  = r_prescale;
                end
                A_COMMAND: begin
                    if (r_write) w_wr_cmd = 1'b1;
                    else         w_rdata  = {r_command[DATA_W-1:2], 2'b00};
                end
                A_ADDRESS: begin
                    if (r_write) w_wr_adr = 1'b1;
                    else         w_rdata  = DATA_W'(r_address);
                end
                A_TXDATA: begin
                    if (r_write && !tx_full) w_push_sel = 1'b1;
                    else                     w_err      = 1'b1;
                end
                A_RXDATA: begin
                    if (!r_write && !rx_empty) begin
                        w_rdata   = DATA_W'(rx_data);
                        w_pop_sel = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                A_STATUS: begin
                    if (!r_write) w_rdata = DATA_W'({status_in[1], status_in[0], rx_empty, tx_full, 4'b0000});
                    else          w_err   = 1'b1;
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    assign w_tx_push    = w_ready && w_push_sel;
    assign PREADY       = w_ready;
    assign PSLVERR      = w_ready && w_err;
    assign PRDATA       = (w_ready && !w_err) ? w_rdata : '0;
    assign tx_push      = w_tx_push;
    assign rx_pop       = w_ready && w_pop_sel;
    assign tx_data      = r_tx_data;
    assign prescale_reg = r_prescale;
    assign address_reg  = r_address;
    assign command_reg  = r_command;

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Setup-phase capture of the request
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
        end
    end

    // Control registers; START/STOP command bits live for one cycle only
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_prescale <= DATA_W'(PRESCALE_RST);
            r_command  <= '0;
            r_address  <= '0;
            r_tx_data  <= '0;
        end else begin
            if (w_ready && w_wr_pre) r_prescale <= r_wdata;
            if (w_ready && w_wr_cmd) r_command <= r_wdata;
            else                     r_command[1:0] <= 2'b00;
            if (w_ready && w_wr_adr) r_address <= r_wdata[7:0];
            if (w_tx_push)           r_tx_data <= r_wdata[7:0];
        end
    end

endmodule
